dlbf_csr_cntrl_nch: RTL and testbench

//  Parametrised N-channel CSR block for the DLBF data-mover path. Decodes BRAM-port (AXI BRAM ctrl) accesses into
//  per-channel go/reset controls and shared block_size/niter/rollover_addr. Adds sticky W1C done status, a

---
 rtl/dlbf_csr_cntrl_nch.sv | 191 +++++++++++++++++++
 tb/tb_dlbf_csr_cntrl_nch.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlbf_csr_cntrl_nch.sv
// N-channel CSR block for the DLBF data-mover: BRAM-port decode, go/reset controls, W1C done status and irq.
// Optional build macro DLBF_CSR_CYCLE_CNT_EN adds the 32-bit CYCLE_CNT run timer at offset 0x18.
module dlbf_csr_cntrl_nch #(
    parameter int          NCH     = 4,
    parameter int          ADDR_W  = 20,
    parameter int          ADDRB_W = 16,
    parameter int          RST_LEN = 16,
    parameter logic [31:0] ID_VAL  = 32'h0123_4568
) (
    input  logic                   BRAM_PORTA_clk,
    input  logic                   BRAM_PORTA_rst,
    input  logic [ADDR_W-1:0]      BRAM_PORTA_addr,
    input  logic [31:0]            BRAM_PORTA_din,
    input  logic                   BRAM_PORTA_en,
    input  logic                   BRAM_PORTA_we,
    input  logic [NCH-1:0]         m_done,
    input  logic [NCH*ADDRB_W-1:0] addrb_wire,
    output logic [NCH-1:0]         go,
    output logic                   m_axis_rst,
    output logic [11:0]            block_size,
    output logic [11:0]            niter,
    output logic [15:0]            rollover_addr,
    output logic                   irq,
    output logic [31:0]            csr_rddata
);

    localparam int RCW = $clog2(RST_LEN + 1);

    localparam logic [7:0] OFF_ID     = 8'h00;
    localparam logic [7:0] OFF_CTRL   = 8'h04;
    localparam logic [7:0] OFF_BSIZE  = 8'h08;
    localparam logic [7:0] OFF_NITER  = 8'h0C;
    localparam logic [7:0] OFF_ROLL   = 8'h10;
    localparam logic [7:0] OFF_IRQEN  = 8'h14;
    localparam logic [7:0] OFF_CYCLE  = 8'h18;
    localparam logic [7:0] OFF_STATUS = 8'h20;
    localparam logic [7:0] OFF_ROW0   = 8'h40;

    logic             is_csr, wr_en, rd_en;
    logic [7:0]       off;
    logic             ctrl_wr, status_wr;

    logic             go_all_q, go_all_d;
    logic [NCH-1:0]   ch_en_q, ch_en_d;
    logic [11:0]      block_size_q, block_size_d;
    logic [11:0]      niter_q, niter_d;
    logic [15:0]      rollover_q, rollover_d;
    logic [NCH-1:0]   irq_en_q, irq_en_d;
    logic [NCH-1:0]   done_sticky_q, done_sticky_d;
    logic [NCH-1:0]   m_done_d_q;
    logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;
    logic             irq_q, irq_d;
    logic [31:0]      rddata_q, rddata_d;
    logic [31:0]      rd_val;
    logic [31:0]      cycle_cnt;
    logic [31:0]      row_val [NCH];
    logic             unused_bits;

    assign is_csr    = BRAM_PORTA_addr[ADDR_W-1];
    assign wr_en     = BRAM_PORTA_en & BRAM_PORTA_we & is_csr;
    assign rd_en     = BRAM_PORTA_en & ~BRAM_PORTA_we & is_csr;
    assign off       = BRAM_PORTA_addr[7:0];
    assign ctrl_wr   = wr_en && (off == OFF_CTRL);
    assign status_wr = wr_en && (off == OFF_STATUS);

    assign unused_bits = ^{BRAM_PORTA_addr[ADDR_W-2:8], BRAM_PORTA_din[31:16]};

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_row
            assign row_val[gi] = 32'(addrb_wire[gi*ADDRB_W +: ADDRB_W]);
        end
    endgenerate

    assign go            = {NCH{go_all_q}} & ch_en_q;
    assign m_axis_rst    = (rst_cnt_q != '0);
    assign block_size    = block_size_q;
    assign niter         = niter_q;
    assign rollover_addr = rollover_q;
    assign irq           = irq_q;
    assign csr_rddata    = rddata_q;

    always_comb begin
        rd_val = '0;
        case (off)
            OFF_ID:     rd_val = ID_VAL;
            OFF_CTRL: begin
                rd_val[4]       = go_all_q;
                rd_val[8 +: NCH] = ch_en_q;
            end
            OFF_BSIZE:  rd_val[11:0] = block_size_q;
            OFF_NITER:  rd_val[11:0] = niter_q;
            OFF_ROLL:   rd_val[15:0] = rollover_q;
            OFF_IRQEN:  rd_val[NCH-1:0] = irq_en_q;
            OFF_CYCLE:  rd_val = cycle_cnt;
            OFF_STATUS: begin
                rd_val[NCH-1:0]   = done_sticky_q;
                rd_val[16 +: NCH] = m_done;
            end
            default: begin
                for (int i = 0; i < NCH; i++) begin
                    if (off == 8'(OFF_ROW0 + 8'(4 * i))) rd_val = row_val[i];
                end
            end
        endcase
    end

    always_comb begin
        go_all_d      = go_all_q;
        ch_en_d       = ch_en_q;
        block_size_d  = block_size_q;
        niter_d       = niter_q;
        rollover_d    = rollover_q;
        irq_en_d      = irq_en_q;
        rddata_d      = rddata_q;
        rst_cnt_d     = (rst_cnt_q != '0) ? rst_cnt_q - 1'b1 : '0;

        if (wr_en) begin
            case (off)
                OFF_CTRL: begin
                    go_all_d = BRAM_PORTA_din[4];
                    ch_en_d  = BRAM_PORTA_din[8 +: NCH];
                end
                OFF_BSIZE: block_size_d = BRAM_PORTA_din[11:0];
                OFF_NITER: niter_d      = BRAM_PORTA_din[11:0];
                OFF_ROLL:  rollover_d   = BRAM_PORTA_din[15:0];
                OFF_IRQEN: irq_en_d     = BRAM_PORTA_din[NCH-1:0];
                default: ;
            endcase
        end
        // A rewrite of rst_req mid-pulse restarts the full pulse length
        if (ctrl_wr && BRAM_PORTA_din[0]) rst_cnt_d = RCW'(RST_LEN);
        if (rd_en) rddata_d = rd_val;

        // New rising edges take priority over a simultaneous W1C
        done_sticky_d = (done_sticky_q & ~(status_wr ? BRAM_PORTA_din[NCH-1:0] : '0))
                      | (m_done & ~m_done_d_q);
        irq_d = |(done_sticky_q & irq_en_q);
    end

    always_ff @(posedge BRAM_PORTA_clk) begin
        if (BRAM_PORTA_rst) begin
            go_all_q      <= 1'b0;
            ch_en_q       <= '1;
            block_size_q  <= 12'd384;
            niter_q       <= 12'd4;
            rollover_q    <= 16'd1536;
            irq_en_q      <= '0;
            done_sticky_q <= '0;
            m_done_d_q    <= '0;
            rst_cnt_q     <= '0;
            irq_q         <= 1'b0;
            rddata_q      <= '0;
        end else begin
            go_all_q      <= go_all_d;
            ch_en_q       <= ch_en_d;
            block_size_q  <= block_size_d;
            niter_q       <= niter_d;
            rollover_q    <= rollover_d;
            irq_en_q      <= irq_en_d;
            done_sticky_q <= done_sticky_d;
            m_done_d_q    <= m_done;
            rst_cnt_q     <= rst_cnt_d;
            irq_q         <= irq_d;
            rddata_q      <= rddata_d;
        end
    end

`ifdef DLBF_CSR_CYCLE_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;

    // Timer restarts when the run is armed and stops once every running channel has reported done
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if (ctrl_wr && BRAM_PORTA_din[4] && !go_all_q) begin
            cycle_cnt_d = '0;
        end else if (|(go & ~done_sticky_q) && (cycle_cnt_q != 32'hFFFF_FFFF)) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge BRAM_PORTA_clk) begin
        if (BRAM_PORTA_rst) cycle_cnt_q <= '0;
        else                cycle_cnt_q <= cycle_cnt_d;
    end

    assign cycle_cnt = cycle_cnt_q;
`else
    assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_dlbf_csr_cntrl_nch.sv
// Randomized scoreboard bench for dlbf_csr_cntrl_nch; read data is checked by a monitor against a queue
// filled from a behavioural register model at read-issue time.
module tb_dlbf_csr_cntrl_nch;

    localparam int NCH     = 4;
    localparam int ADDR_W  = 20;
    localparam int ADDRB_W = 16;
    localparam int RST_LEN = 16;

    logic                   clk = 1'b0;
    logic                   srst;
    logic [ADDR_W-1:0]      addr;
    logic [31:0]            din;
    logic                   en, we;
    logic [NCH-1:0]         m_done;
    logic [NCH*ADDRB_W-1:0] addrb_wire;
    logic [NCH-1:0]         go;
    logic                   m_axis_rst;
    logic [11:0]            block_size, niter;
    logic [15:0]            rollover_addr;
    logic                   irq;
    logic [31:0]            csr_rddata;

    dlbf_csr_cntrl_nch dut (
        .BRAM_PORTA_clk (clk),
        .BRAM_PORTA_rst (srst),
        .BRAM_PORTA_addr(addr),
        .BRAM_PORTA_din (din),
        .BRAM_PORTA_en  (en),
        .BRAM_PORTA_we  (we),
        .m_done         (m_done),
        .addrb_wire     (addrb_wire),
        .go             (go),
        .m_axis_rst     (m_axis_rst),
        .block_size     (block_size),
        .niter          (niter),
        .rollover_addr  (rollover_addr),
        .irq            (irq),
        .csr_rddata     (csr_rddata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct { logic [7:0] off; logic [31:0] val; } rd_exp_t;
    rd_exp_t exp_q[$];

    // Register model
    logic           m_go_all;
    logic [NCH-1:0] m_ch_en, m_irq_en, m_sticky;
    logic [11:0]    m_bs, m_ni;
    logic [15:0]    m_ro;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Monitor: a CSR read seen on a rising edge presents data from that edge on
    logic rd_fire_q = 1'b0;
    always @(posedge clk) rd_fire_q <= en & ~we & addr[ADDR_W-1];

    always @(negedge clk) begin
        if (rd_fire_q) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got 0x%08h expected no read", csr_rddata);
            end else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                check($sformatf("rd[0x%02h]", e.off), csr_rddata, e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_go_all = 1'b0; m_ch_en = '1; m_irq_en = '0; m_sticky = '0;
        m_bs = 12'd384; m_ni = 12'd4; m_ro = 16'd1536;
    endtask

    function automatic logic [31:0] exp_read(input logic [7:0] off);
        logic [31:0] v;
        v = 32'h0;
        case (off)
            8'h00: v = 32'h0123_4568;
            8'h04: v = (32'(m_ch_en) << 8) | (32'(m_go_all) << 4);
            8'h08: v = 32'(m_bs);
            8'h0C: v = 32'(m_ni);
            8'h10: v = 32'(m_ro);
            8'h14: v = 32'(m_irq_en);
            8'h20: v = (32'(m_done) << 16) | 32'(m_sticky);
            default: begin
                if (off >= 8'h40 && int'(off) < 8'h40 + 4 * NCH && off[1:0] == 2'b00)
                    v = 32'(addrb_wire[((int'(off) - 8'h40) / 4) * ADDRB_W +: ADDRB_W]);
            end
        endcase
        return v;
    endfunction

    task automatic model_write(input logic [7:0] off, input logic [31:0] d);
        case (off)
            8'h04: begin m_go_all = d[4]; m_ch_en = d[8 +: NCH]; end
            8'h08: m_bs = d[11:0];
            8'h0C: m_ni = d[11:0];
            8'h10: m_ro = d[15:0];
            8'h14: m_irq_en = d[NCH-1:0];
            8'h20: m_sticky = m_sticky & ~d[NCH-1:0];
            default: ;
        endcase
    endtask

    task automatic raw_access(input logic [ADDR_W-1:0] a, input logic w, input logic [31:0] d);
        addr = a; din = d; we = w; en = 1'b1;
        tick();
        en = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        raw_access({1'b1, 11'h0, off}, 1'b1, d);
        model_write(off, d);
    endtask

    task automatic rd_exp(input logic [7:0] off, input logic [31:0] v);
        exp_q.push_back('{off, v});
        raw_access({1'b1, 11'h0, off}, 1'b0, 32'h0);
    endtask

    task automatic rd(input logic [7:0] off);
        rd_exp(off, exp_read(off));
    endtask

    task automatic check_outputs(input string tag);
        check({tag, " go"}, 32'(go), 32'(m_go_all ? m_ch_en : '0));
        check({tag, " block_size"}, 32'(block_size), 32'(m_bs));
        check({tag, " niter"}, 32'(niter), 32'(m_ni));
        check({tag, " rollover"}, 32'(rollover_addr), 32'(m_ro));
    endtask

    logic [7:0] rand_offs [15] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h20,
                                   8'h40, 8'h44, 8'h48, 8'h4C, 8'h50, 8'hF0, 8'h05};

    initial begin
        int cnt;
        srst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; din = '0; m_done = '0;
        addrb_wire = '0;
        model_reset();
        repeat (3) tick();
        srst = 1'b0;

        // Reset state
        check("reset csr_rddata", csr_rddata, 32'h0);
        check("reset m_axis_rst", 32'(m_axis_rst), 32'h0);
        check("reset irq", 32'(irq), 32'h0);
        check_outputs("reset");
        rd(8'h00); rd(8'h04); rd(8'h08); rd(8'h0C); rd(8'h10); rd(8'h14); rd(8'h18); rd(8'h20);

        // go from CTRL, no stream reset
        wr(8'h04, 32'h0000_0510);
        check("ctrl go", 32'(go), 32'h5);
        check("ctrl no rst", 32'(m_axis_rst), 32'h0);
        rd(8'h04);

        // Stream reset pulse, extended by a rewrite after 10 cycles
        wr(8'h04, 32'h1);
        check("rst pulse start", 32'(m_axis_rst), 32'h1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (m_axis_rst) cnt++;
            if (i != 9) tick();
        end
        wr(8'h04, 32'h1);
        for (int i = 0; i < 40; i++) begin
            if (m_axis_rst) cnt++;
            tick();
        end
        check("rst pulse length", 32'(cnt), 32'd26);
        check("rst pulse ended", 32'(m_axis_rst), 32'h0);
        rd(8'h04);

        // Sticky done, irq, set-wins-over-clear
        wr(8'h14, 32'h2);
        m_done = 4'b0010;
        tick();
        m_sticky |= 4'b0010;
        check("irq lag", 32'(irq), 32'h0);
        tick();
        check("irq set", 32'(irq), 32'h1);
        rd(8'h20);
        m_done = 4'b0000;
        tick();
        m_done = 4'b0010;
        wr(8'h20, 32'h2);
        m_sticky |= 4'b0010;
        rd(8'h20);
        wr(8'h20, 32'h2);
        rd(8'h20);
        check("irq cleared", 32'(irq), 32'h0);
        m_done = 4'b0000;
        tick();

        // Row readback, unmapped and non-CSR accesses
        for (int i = 0; i < NCH; i++) addrb_wire[i*ADDRB_W +: ADDRB_W] = 16'($urandom);
        addrb_wire[3*ADDRB_W +: ADDRB_W] = 16'hBEEF;
        rd_exp(8'h4C, 32'h0000_BEEF);
        for (int i = 0; i < NCH; i++) rd(8'(8'h40 + 4 * i));
        rd_exp(8'h50, 32'h0);
        rd_exp(8'hF0, 32'h0);
        wr(8'hF0, 32'hFFFF_FFFF);
        raw_access(20'h0_0008, 1'b1, 32'h0000_0ABC);
        check_outputs("non-csr wr");
        rd(8'h08);
        raw_access(20'h0_0000, 1'b0, 32'h0);
        check("non-csr rd hold", csr_rddata, 32'(m_bs));

        // Randomized register traffic
        for (int n = 0; n < 60; n++) begin
            logic [7:0]  o;
            logic [31:0] d;
            o = rand_offs[$urandom_range(0, 14)];
`ifdef DLBF_CSR_CYCLE_CNT_EN
            if (o == 8'h18) o = 8'h08;
`endif
            d = $urandom;
            if ($urandom_range(0, 1) == 1) wr(o, d);
            else                           rd(o);
            check_outputs($sformatf("rand%0d", n));
        end

`ifdef DLBF_CSR_CYCLE_CNT_EN
        // Run timer: 100 counted cycles until channel 0 reports done
        wr(8'h04, 32'h0);
        wr(8'h20, 32'hF);
        wr(8'h04, 32'h0000_0110);
        repeat (99) tick();
        m_done = 4'b0001;
        repeat (20) tick();
        rd_exp(8'h18, 32'd100);
        repeat (10) tick();
        rd_exp(8'h18, 32'd100);
        m_done = 4'b0000;
        m_sticky |= 4'b0001;
`endif

        // Reset mid-pulse aborts it and restores defaults
        wr(8'h04, 32'h0000_0311);
        wr(8'h08, 32'h0000_0123);
        check("pre-reset rst", 32'(m_axis_rst), 32'h1);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        model_reset();
        check("post-reset rst", 32'(m_axis_rst), 32'h0);
        check("post-reset rddata", csr_rddata, 32'h0);
        tick();
        check("post-reset rst held", 32'(m_axis_rst), 32'h0);
        check_outputs("post-reset");
        rd(8'h04); rd(8'h08);
        repeat (3) tick();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rd_pending: got %0d outstanding expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
